reg_read_sequencer: RTL and testbench
=====================================

REG_READ_SEQUENCER -- requirements
Module: reg_read_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, register data width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  read-burst request present.
REQ-005 req_addr  input  3  first register address of the burst.
REQ-006 req_len  input  3  beats minus one (0 = 1 beat, 7 = 8 beats).
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 rf_raddr  output  3  read address to the 8-entry register file (combinational read).
REQ-009 rf_rdata  input  WIDTH  register file read data for rf_raddr, same cycle.
REQ-010 wr_en  input  1  register file write enable, snooped (same signal driving the write decoder).
REQ-011 wr_addr  input  3  register file write address, snooped.
REQ-012 wr_data  input  WIDTH  register file write data, snooped.
REQ-013 rd_valid  output  1  output beat valid.
REQ-014 rd_ready  input  1  consumer accepts beat when rd_valid && rd_ready.
REQ-015 rd_data  output  WIDTH  registered beat data.
REQ-016 rd_addr  output  3  register address the beat was read from.
REQ-017 rd_last  output  1  marks final beat of a burst.

Function
REQ-018 The FSM SHALL have two states: IDLE and BURST.
REQ-019 In IDLE, req_ready SHALL be 1; in BURST, req_ready SHALL be 0.
REQ-020 On acceptance, the block SHALL capture cur_addr = req_addr and remaining = req_len, then enter BURST next cycle.
REQ-021 rf_raddr SHALL equal cur_addr in BURST and req_addr in IDLE.
REQ-022 In BURST, a load SHALL occur when the output stage is empty or the current beat is accepted (!rd_valid || rd_ready).
REQ-023 A load SHALL register rd_data = rf_rdata, rd_addr = cur_addr, rd_last = (remaining == 0), and rd_valid = 1.
REQ-024 After a load, cur_addr SHALL increment modulo 8 (7 wraps to 0) and remaining SHALL decrement.
REQ-025 The load with remaining == 0 SHALL return the FSM to IDLE.
REQ-026 While rd_valid && !rd_ready, rd_data, rd_addr and rd_last SHALL hold stable and no load SHALL occur.
REQ-027 Acceptance at edge N SHALL give the first rd_valid after edge N+1 (2-cycle latency).
REQ-028 With rd_ready held 1, beats SHALL stream one per cycle with no bubbles.
REQ-029 rd_valid SHALL clear after an accepted beat when no load occurs in the same cycle.
REQ-030 A new request SHALL be accepted in IDLE even while the final beat of the prior burst is still stalled.
REQ-031 The first load of the new burst SHALL wait per REQ-022.

Reset
REQ-032 Reset SHALL set state = IDLE, cur_addr = 0, remaining = 0, rd_valid = 0, rd_data = 0, rd_addr = 0, rd_last = 0.
REQ-033 Reset SHALL take priority over all other events, including mid-burst; the burst SHALL be abandoned and no further beats SHALL be issued.

Configuration
REQ-034 Macro WRITE_BYPASS_EN defined: on a load with wr_en = 1 and wr_addr = cur_addr, rd_data SHALL take wr_data instead of rf_rdata.
REQ-035 Macro WRITE_BYPASS_EN undefined: rd_data SHALL always take rf_rdata; same-cycle writes are seen only on later reads.

Verification
REQ-036 Reset, then req_addr = 2, req_len = 0, rd_ready = 1 -> rd_valid one cycle, rd_addr = 2, rd_last = 1, rd_data = rf[2], latency 2.
REQ-037 req_addr = 6, req_len = 3 -> rd_addr sequence 6, 7, 0, 1; rd_last only on addr 1; 4 consecutive cycles.
REQ-038 req_len = 7, rd_ready toggled 1/0 per cycle -> all 8 registers delivered once in order; outputs stable during stalls.
REQ-039 Load of addr 3 coincides with wr_en = 1, wr_addr = 3, wr_data = 0xA5A5A5A5 -> rd_data = 0xA5A5A5A5 with WRITE_BYPASS_EN, old rf[3] without.
REQ-040 Assert reset during beat 2 of an 8-beat burst -> next cycle rd_valid = 0, req_ready = 1; no further beats.
REQ-041 Request accepted while last beat stalled (rd_ready = 0 for 3 cycles) -> old beat held until accepted, then new burst beats follow.

Source files
------------

// File: rtl/reg_read_sequencer.sv
// Burst reader: walks the 8-entry register file from a start address and streams beats out.
// Optional WRITE_BYPASS_EN forwards a same-cycle snooped write into the loaded beat.
module reg_read_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_addr,
  input  logic [2:0]       req_len,
  output logic             req_ready,
  output logic [2:0]       rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       rd_addr,
  output logic             rd_last
);

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;

  logic             state_q, state_d;
  logic [2:0]       curAddr_q, curAddr_d;
  logic [2:0]       remaining_q, remaining_d;
  logic             rdValid_q, rdValid_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;
  logic [2:0]       rdAddr_q, rdAddr_d;
  logic             rdLast_q, rdLast_d;
  logic             load;
  logic [WIDTH-1:0] loadData;

  assign req_ready = (state_q == IDLE);
  assign rf_raddr  = (state_q == BURST) ? curAddr_q : req_addr;
  assign load      = (state_q == BURST) && (!rdValid_q || rd_ready);

`ifdef WRITE_BYPASS_EN
  // A write landing on the address being loaded would otherwise be missed by this beat.
  always_comb begin
    loadData = rf_rdata;
    if (wr_en && (wr_addr == curAddr_q)) begin
      loadData = wr_data;
    end
  end
`else
  logic unusedSnoop;
  assign unusedSnoop = ^{wr_en, wr_addr, wr_data};
  assign loadData    = rf_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    remaining_d = remaining_q;
    rdValid_d   = rdValid_q;
    rdData_d    = rdData_q;
    rdAddr_d    = rdAddr_q;
    rdLast_d    = rdLast_q;

    if (state_q == IDLE) begin
      if (req_valid) begin
        curAddr_d   = req_addr;
        remaining_d = req_len;
        state_d     = BURST;
      end
    end else if (load) begin
      curAddr_d   = curAddr_q + 3'd1;
      remaining_d = remaining_q - 3'd1;
      if (remaining_q == 3'd0) begin
        state_d = IDLE;
      end
    end

    // The output stage drains independently of the FSM, so a stalled last beat survives into IDLE.
    if (load) begin
      rdValid_d = 1'b1;
      rdData_d  = loadData;
      rdAddr_d  = curAddr_q;
      rdLast_d  = (remaining_q == 3'd0);
    end else if (rdValid_q && rd_ready) begin
      rdValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      curAddr_q   <= 3'd0;
      remaining_q <= 3'd0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      rdAddr_q    <= 3'd0;
      rdLast_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      curAddr_q   <= curAddr_d;
      remaining_q <= remaining_d;
      rdValid_q   <= rdValid_d;
      rdData_q    <= rdData_d;
      rdAddr_q    <= rdAddr_d;
      rdLast_q    <= rdLast_d;
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_data  = rdData_q;
  assign rd_addr  = rdAddr_q;
  assign rd_last  = rdLast_q;

endmodule

// File: tb/tb_reg_read_sequencer.sv
// Scoreboard bench for reg_read_sequencer with a behavioural 8-entry register file.
module tb_reg_read_sequencer;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  addr;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic [2:0]  reqAddr;
  logic [2:0]  reqLen;
  logic        reqReady;
  logic [2:0]  rfRaddr;
  logic [31:0] rfRdata;
  logic        wrEn;
  logic [2:0]  wrAddr;
  logic [31:0] wrData;
  logic        rdValid;
  logic        rdReady;
  logic [31:0] rdData;
  logic [2:0]  rdAddr;
  logic        rdLast;

  logic [31:0] rf [8];
  beat_t       sbQ [$];
  int          assertCount = 0;
  int          failCount   = 0;

  reg_read_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_addr(reqAddr), .req_len(reqLen), .req_ready(reqReady),
    .rf_raddr(rfRaddr), .rf_rdata(rfRdata),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_valid(rdValid), .rd_ready(rdReady),
    .rd_data(rdData), .rd_addr(rdAddr), .rd_last(rdLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on the rising edge.
  assign rfRdata = rf[rfRaddr];
  always @(posedge clk) begin
    if (wrEn) rf[wrAddr] <= wrData;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Every visible beat, stalled or not, must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && rdValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_beat", {61'd0, rdAddr}, 64'hFFFF);
      end else begin
        checkOutput("beat_data", {32'd0, rdData}, {32'd0, sbQ[0].data});
        checkOutput("beat_addr", {61'd0, rdAddr}, {61'd0, sbQ[0].addr});
        checkOutput("beat_last", {63'd0, rdLast}, {63'd0, sbQ[0].last});
        if (rdReady) void'(sbQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] addr, input logic [2:0] len, input bit bypass);
    int    waitCycles = 0;
    beat_t b;
    reqAddr  = addr;
    reqLen   = len;
    reqValid = 1'b1;
    @(negedge clk);
    while (!reqReady && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!reqReady) begin
      checkOutput("req_accept_timeout", 64'd0, 64'd1);
      reqValid = 1'b0;
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      b.addr = addr + i[2:0];
      b.data = rf[b.addr];
      b.last = (i == int'(len));
`ifdef WRITE_BYPASS_EN
      if (bypass && b.addr == 3'd3) b.data = 32'hA5A5A5A5;
`else
      if (bypass && b.addr == 3'd3) b.data = rf[3];
`endif
      sbQ.push_back(b);
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int c = 0;
    while ((sbQ.size() != 0 || rdValid) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput(tag, {63'd0, (sbQ.size() == 0 && !rdValid)}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    for (int i = 0; i < 8; i++) rf[i] = 32'hC0DE0000 + 32'h111 * i;
    reset = 1'b1; reqValid = 1'b0; reqAddr = 3'd0; reqLen = 3'd0;
    wrEn = 1'b0; wrAddr = 3'd0; wrData = 32'd0; rdReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rd_valid", {63'd0, rdValid}, 64'd0);
    checkOutput("reset_req_ready", {63'd0, reqReady}, 64'd1);
    checkOutput("reset_rd_data", {32'd0, rdData}, 64'd0);
    checkOutput("reset_rd_addr", {61'd0, rdAddr}, 64'd0);
    checkOutput("reset_rd_last", {63'd0, rdLast}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single beat from addr 2: two-cycle latency, one valid cycle.
    applyStimulus(3'd2, 3'd0, 1'b0);
    checkOutput("lat_busy_ready", {63'd0, reqReady}, 64'd0);
    checkOutput("lat_not_yet", {63'd0, rdValid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_valid", {63'd0, rdValid}, 64'd1);
    @(posedge clk); #1;
    checkOutput("lat_single", {63'd0, rdValid}, 64'd0);
    waitDrain("drain_single");

    // Wrapping burst 6,7,0,1 streams without bubbles.
    applyStimulus(3'd6, 3'd3, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_valid", {63'd0, rdValid}, 64'd1);
      @(posedge clk); #1;
    end
    checkOutput("stream_end", {63'd0, rdValid}, 64'd0);
    waitDrain("drain_wrap");

    // Full 8-beat burst with rd_ready toggling every cycle.
    applyStimulus(3'd0, 3'd7, 1'b0);
    repeat (24) begin
      @(posedge clk); #1;
      rdReady = ~rdReady;
    end
    rdReady = 1'b1;
    waitDrain("drain_toggle");

    // Same-cycle write to the address being loaded.
    applyStimulus(3'd3, 3'd0, 1'b1);
    wrEn = 1'b1; wrAddr = 3'd3; wrData = 32'hA5A5A5A5;
    @(posedge clk); #1;
    wrEn = 1'b0;
    waitDrain("drain_bypass");
    applyStimulus(3'd3, 3'd0, 1'b0);
    waitDrain("drain_after_write");

    // Reset while the second beat of an 8-beat burst is on the output.
    applyStimulus(3'd0, 3'd7, 1'b0);
    waitCycles = 0;
    @(negedge clk);
    while (!(rdValid && rdAddr == 3'd1) && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("reset_found_beat2", {63'd0, (rdValid && rdAddr == 3'd1)}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_rd_valid", {63'd0, rdValid}, 64'd0);
    checkOutput("midreset_req_ready", {63'd0, reqReady}, 64'd1);
    sbQ.delete();
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checkOutput("no_beat_after_reset", {63'd0, rdValid}, 64'd0);
    end

    // New request accepted while the previous last beat is stalled.
    rdReady = 1'b0;
    applyStimulus(3'd5, 3'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("stall_last_valid", {63'd0, rdValid}, 64'd1);
    checkOutput("stall_idle_ready", {63'd0, reqReady}, 64'd1);
    applyStimulus(3'd1, 3'd2, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("stall_held_addr", {61'd0, rdAddr}, 64'd5);
    rdReady = 1'b1;
    waitDrain("drain_overlap");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
